// File: rtl/fft_frame_sequencer.sv
// Streams one buffered frame at a time into the FFT sink, with a 2-entry skid FIFO
// absorbing sink backpressure and a one-deep queue for frames announced while busy.
module fft_frame_sequencer #(
    parameter int W        = 16,
    parameter int NSamples = 1024,
    parameter int IDX_W    = 10,
    parameter int DROP_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_ready,
    output logic              buf_rd_en,
    input  logic [W-1:0]      buf_rd_data,
    output logic              sink_valid,
    input  logic              sink_ready,
    output logic              sink_sop,
    output logic              sink_eop,
    output logic [W-1:0]      sink_data,
    output logic [IDX_W-1:0]  sink_index,
    output logic              busy,
    output logic              frame_done,
    output logic              overrun,
    output logic [DROP_W-1:0] frames_dropped
);

    localparam logic [IDX_W:0]   NS   = (IDX_W+1)'(NSamples);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NSamples - 1);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    state_t           state, state_nxt;
    logic             pending, pending_nxt;
    logic             drop;
    logic [IDX_W:0]   rd_cnt;
    logic             rd_inflight;
    logic [IDX_W-1:0] rd_idx;

    logic [W-1:0]     fifo_data [2];
    logic [IDX_W-1:0] fifo_idx  [2];
    logic             wr_ptr, rd_ptr;
    logic [1:0]       fifo_cnt;

    logic             head_valid, xfer, eop_xfer;
    logic [IDX_W-1:0] head_idx;
    logic [1:0]       occ_after_pop;

    assign head_valid = (fifo_cnt != 2'd0);
    assign head_idx   = fifo_idx[rd_ptr];
    assign xfer       = head_valid && sink_ready;
    assign eop_xfer   = xfer && (head_idx == LAST);

    // Entries held or in flight once this cycle's pop is accounted for; never exceeds 2.
    assign occ_after_pop = fifo_cnt + {1'b0, rd_inflight} - {1'b0, xfer};
    assign buf_rd_en     = (state == STREAM) && (rd_cnt < NS) && (occ_after_pop < 2'd2);

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        drop        = 1'b0;
        case (state)
            IDLE: begin
                // A queued frame and a new pulse together: one starts, the other stays queued.
                pending_nxt = pending && frame_ready;
                if (frame_ready || pending) state_nxt = STREAM;
            end
            STREAM: begin
                if (buf_rd_en && rd_cnt == NS - 1'b1) state_nxt = DRAIN;
                pending_nxt = pending || frame_ready;
                drop        = pending && frame_ready;
            end
            DRAIN: begin
                if (eop_xfer) begin
                    state_nxt   = pending ? STREAM : IDLE;
                    pending_nxt = frame_ready;
                end else begin
                    pending_nxt = pending || frame_ready;
                    drop        = pending && frame_ready;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            pending        <= 1'b0;
            rd_cnt         <= '0;
            rd_inflight    <= 1'b0;
            rd_idx         <= '0;
            wr_ptr         <= 1'b0;
            rd_ptr         <= 1'b0;
            fifo_cnt       <= 2'd0;
            frame_done     <= 1'b0;
            overrun        <= 1'b0;
            frames_dropped <= '0;
        end else begin
            state       <= state_nxt;
            pending     <= pending_nxt;
            if (state_nxt == STREAM && state != STREAM) rd_cnt <= '0;
            else                                         rd_cnt <= rd_cnt + (IDX_W+1)'(buf_rd_en);
            rd_inflight <= buf_rd_en;
            rd_idx      <= rd_cnt[IDX_W-1:0];
            if (rd_inflight) wr_ptr <= ~wr_ptr;
            if (xfer)        rd_ptr <= ~rd_ptr;
            fifo_cnt    <= fifo_cnt + {1'b0, rd_inflight} - {1'b0, xfer};
            frame_done  <= eop_xfer;
            overrun     <= drop;
            if (drop && frames_dropped != {DROP_W{1'b1}}) frames_dropped <= frames_dropped + 1'b1;
        end
    end

    // Payload storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (rd_inflight) begin
            fifo_data[wr_ptr] <= buf_rd_data;
            fifo_idx[wr_ptr]  <= rd_idx;
        end
    end

    assign sink_valid = head_valid;
    assign sink_data  = head_valid ? fifo_data[rd_ptr] : '0;
    assign sink_index = head_valid ? head_idx : '0;
    assign sink_sop   = head_valid && (head_idx == '0);
    assign sink_eop   = head_valid && (head_idx == LAST);
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Bench for fft_frame_sequencer: frame-level reference model (beat queue, outstanding-frame
// count) checked every cycle, directed scenarios with literal timing, then random traffic.
module tb_fft_frame_sequencer;
    localparam int W = 16, N = 8, IDX_W = 3, DROP_W = 2;

    logic              clk = 1'b0, reset = 1'b1, frame_ready = 1'b0, sink_ready = 1'b0;
    logic [W-1:0]      buf_rd_data = '0;
    logic              buf_rd_en, sink_valid, sink_sop, sink_eop, busy, frame_done, overrun;
    logic [W-1:0]      sink_data;
    logic [IDX_W-1:0]  sink_index;
    logic [DROP_W-1:0] frames_dropped;

    fft_frame_sequencer #(.W(W), .NSamples(N), .IDX_W(IDX_W), .DROP_W(DROP_W)) dut (
        .clk(clk), .reset(reset), .frame_ready(frame_ready), .buf_rd_en(buf_rd_en),
        .buf_rd_data(buf_rd_data), .sink_valid(sink_valid), .sink_ready(sink_ready),
        .sink_sop(sink_sop), .sink_eop(sink_eop), .sink_data(sink_data),
        .sink_index(sink_index), .busy(busy), .frame_done(frame_done), .overrun(overrun),
        .frames_dropped(frames_dropped));

    always #5 clk = ~clk;

    int checks = 0, errors = 0, done_cnt = 0, acc_next = 0;

    function automatic logic [W-1:0] gen(input int fr, input int i);
        return W'(fr * 256 + i * 17 + 3);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Frame buffer: synchronous read, frames served in acceptance order.
    int buf_frame = 0, buf_idx = 0;
    always @(posedge clk) begin
        if (reset) begin
            buf_idx   <= 0;
            buf_frame <= acc_next;
        end else if (buf_rd_en) begin
            buf_rd_data <= gen(buf_frame, buf_idx);
            if (buf_idx == N - 1) begin
                buf_idx   <= 0;
                buf_frame <= buf_frame + 1;
            end else buf_idx <= buf_idx + 1;
        end
    end

    // Reference model: every accepted frame appends N beats; a frame stays outstanding until
    // its last beat transfers; a request is dropped if two frames would remain outstanding.
    typedef struct packed { logic [W-1:0] d; logic [IDX_W-1:0] idx; } beat_t;
    beat_t q[$];
    int    outstanding = 0, drops = 0, rds = 0, xfers = 0;
    logic  exp_busy = 0, exp_done = 0, exp_ovr = 0, exp_zero = 1, prev_stall = 0;
    logic [W-1:0] p_data;
    logic [IDX_W-1:0] p_idx;
    logic  p_sop, p_eop;

    always @(negedge clk) begin
        beat_t b;
        logic  xf, completed, accepted, dropped;
        int    ob;
        if (frame_done) done_cnt++;
        chk("busy", busy, exp_busy);
        chk("frame_done", frame_done, exp_done);
        chk("overrun", overrun, exp_ovr);
        chk("frames_dropped", frames_dropped, drops);
        if (exp_zero) begin
            chk("rst_valid", sink_valid, 0); chk("rst_rd_en", buf_rd_en, 0);
            chk("rst_data", sink_data, 0);   chk("rst_index", sink_index, 0);
            chk("rst_sop", sink_sop, 0);     chk("rst_eop", sink_eop, 0);
        end
        if (prev_stall) begin
            chk("stall_valid", sink_valid, 1); chk("stall_data", sink_data, p_data);
            chk("stall_index", sink_index, p_idx);
            chk("stall_sop", sink_sop, p_sop); chk("stall_eop", sink_eop, p_eop);
        end
        xf = sink_valid && sink_ready;
        completed = 0;
        if (xf) begin
            if (q.size() == 0) chk("unexpected_beat", 1, 0);
            else begin
                b = q.pop_front();
                chk("beat_data", sink_data, b.d);
                chk("beat_index", sink_index, b.idx);
                chk("beat_sop", sink_sop, b.idx == 0);
                chk("beat_eop", sink_eop, b.idx == IDX_W'(N - 1));
                completed = (b.idx == IDX_W'(N - 1));
            end
        end
        if (reset) begin
            q.delete();
            outstanding = 0; drops = 0; rds = 0; xfers = 0;
            exp_busy = 0; exp_done = 0; exp_ovr = 0; exp_zero = 1; prev_stall = 0;
        end else begin
            rds   += int'(buf_rd_en);
            xfers += int'(xf);
            chk("outstanding_reads_le2", (rds - xfers) <= 2, 1);
            ob = outstanding;
            accepted = 0; dropped = 0;
            if (frame_ready) begin
                if (ob - int'(completed) >= 2) dropped = 1;
                else accepted = 1;
            end
            exp_busy    = (ob == 0) ? accepted : ((ob - int'(completed)) > 0);
            outstanding = ob - int'(completed) + int'(accepted);
            if (accepted) begin
                for (int i = 0; i < N; i++) q.push_back('{d: gen(acc_next, i), idx: IDX_W'(i)});
                acc_next++;
            end
            exp_done = completed;
            exp_ovr  = dropped;
            if (dropped && drops < 3) drops++;
            exp_zero   = 0;
            prev_stall = sink_valid && !sink_ready;
            p_data = sink_data; p_idx = sink_index; p_sop = sink_sop; p_eop = sink_eop;
        end
    end

    task automatic drain(input int budget);
        int quiet, n;
        frame_ready = 0; sink_ready = 1; quiet = 0; n = 0;
        while (quiet < 4 && n < budget) begin
            step();
            quiet = busy ? 0 : quiet + 1;
            n++;
        end
        chk("drain_reaches_idle", quiet >= 4, 1);
    endtask

    initial begin
        int nd, bzero, d0;
        repeat (3) step();
        reset = 0;

        // Single frame with literal latencies.
        sink_ready = 1;
        step(); frame_ready = 1;
        step(); frame_ready = 0;
        chk("lat_first_rd", buf_rd_en, 1);
        step(); step();
        chk("lat_first_valid", sink_valid, 1);
        chk("lat_first_sop", sink_sop, 1);
        chk("lat_first_index", sink_index, 0);
        repeat (7) step();
        chk("lat_eop", sink_eop, 1);
        chk("lat_eop_index", sink_index, 7);
        step();
        chk("lat_frame_done", frame_done, 1);
        chk("lat_busy_low", busy, 0);

        // Backpressure pattern 1,0,0.
        for (int c = 0; c < 40; c++) begin
            step();
            frame_ready = (c == 0);
            sink_ready  = (c % 3 == 0);
        end
        drain(100);

        // Back-to-back: second request at beat 3, no idle between frames.
        step(); frame_ready = 1;
        step(); frame_ready = 0;
        for (int n = 0; n < 40 && !(sink_valid && sink_index == 3); n++) step();
        chk("b2b_reach_beat3", sink_valid && sink_index == 3, 1);
        frame_ready = 1;
        nd = 0; bzero = 0;
        for (int n = 0; n < 60 && nd < 2; n++) begin
            step(); frame_ready = 0;
            if (frame_done) nd++;
            else if (!busy) bzero++;
        end
        chk("b2b_two_done", nd, 2);
        chk("b2b_no_idle_gap", bzero, 0);
        chk("b2b_no_drop", frames_dropped, 0);
        drain(100);

        // Overrun: stalled sink, seven requests -> one runs, one queued, five dropped.
        sink_ready = 0;
        for (int k = 0; k < 7; k++) begin
            step(); frame_ready = 1;
            step(); frame_ready = 0;
        end
        step();
        chk("ovr_saturated", frames_dropped, 3);
        drain(100);

        // Reset at beat 4 while stalled.
        step(); frame_ready = 1;
        step(); frame_ready = 0;
        for (int n = 0; n < 40 && !(sink_valid && sink_index == 4); n++) step();
        chk("rst_reach_beat4", sink_valid && sink_index == 4, 1);
        sink_ready = 0; reset = 1;
        step(); reset = 0;
        chk("rst_abort_valid", sink_valid, 0);
        d0 = done_cnt;
        repeat (10) step();
        chk("rst_no_done", done_cnt - d0, 0);
        sink_ready = 1; frame_ready = 1;
        step(); frame_ready = 0;
        for (int n = 0; n < 10 && !sink_valid; n++) step();
        chk("rst_restart_sop", sink_sop, 1);
        chk("rst_restart_index", sink_index, 0);
        drain(100);

        // frame_ready coincides with the eop transfer while a frame is queued.
        d0 = done_cnt;
        step(); frame_ready = 1;
        step(); frame_ready = 0;
        for (int n = 0; n < 40 && !(sink_valid && sink_index == 3); n++) step();
        frame_ready = 1;
        step(); frame_ready = 0;
        for (int n = 0; n < 40 && !(sink_valid && sink_eop); n++) step();
        chk("sim_reach_eop", sink_valid && sink_eop, 1);
        frame_ready = 1;
        step(); frame_ready = 0;
        chk("sim_no_overrun", overrun, 0);
        chk("sim_done", frame_done, 1);
        drain(200);
        chk("sim_three_frames", done_cnt - d0, 3);
        chk("sim_no_drop", frames_dropped, 0);

        // Random traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            step();
            reset       = ($urandom_range(0, 499) == 0);
            frame_ready = !reset && ($urandom_range(0, 9) == 0);
            sink_ready  = ($urandom_range(0, 3) != 0);
        end
        reset = 0;
        drain(300);
        drain(300);
        chk("final_queue_empty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fft_frame_sequencer.md
Name: fft_frame_sequencer

Overview:
- Sequences one buffered audio frame at a time from the frame buffer into the FFT sink interface.
- Generates buffer read strobes, sop/eop framing and the per-sample index used by the Hanning-window coefficient lookup.
- Honours FFT sink_ready backpressure without losing samples, and counts frames dropped when the buffer signals a new frame faster than the FFT accepts them.
- Sits between the frame buffer and the windowing/FFT stage.

Parameters:
- W, 16, sample width in bits.
- NSamples, 1024, samples per frame; must be a power of 2 and at least 4.
- IDX_W, 10, sample index width; equals log2(NSamples).
- DROP_W, 8, width of the dropped-frame counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- frame_ready  in  1  single-cycle pulse: a complete frame of NSamples is available in the buffer.
- buf_rd_en  out  1  buffer read strobe; buffer returns buf_rd_data exactly 1 cycle later.
- buf_rd_data  in  W  buffer read data.
- sink_valid  out  1  FFT sink valid.
- sink_ready  in  1  FFT sink ready; a beat transfers when sink_valid && sink_ready.
- sink_sop  out  1  high on beat with index 0.
- sink_eop  out  1  high on beat with index NSamples-1.
- sink_data  out  W  sample to window/FFT.
- sink_index  out  IDX_W  index of current beat within frame.
- busy  out  1  high while a frame is being read or drained.
- frame_done  out  1  1-cycle pulse, cycle after the eop beat transfers.
- overrun  out  1  1-cycle pulse when a frame_ready is dropped.
- frames_dropped  out  DROP_W  saturating count of dropped frames.

Behaviour:
- Reset values: all outputs 0. State = IDLE. Pending flag clear, skid FIFO empty, counters 0.
- Reset mid-frame aborts immediately: no eop and no frame_done are emitted; in-flight read data is discarded.

State machine:
- IDLE: on frame_ready, or pending set, go to STREAM (pending cleared, read counter = 0).
- STREAM: issue reads until NSamples reads are issued, then go to DRAIN.
- DRAIN: wait for the eop beat to transfer. The cycle after transfer, pulse frame_done.
  - If pending is set, go to STREAM directly. Back-to-back frames carry no idle gap beyond this cycle.
  - Otherwise go to IDLE.
- busy = (state != IDLE).

Read/backpressure:
- Output uses a 2-entry skid FIFO.
- occupancy = FIFO count + reads in flight (0 or 1).
- buf_rd_en = (state == STREAM) && reads_issued < NSamples && occupancy_after_pop < 2, where occupancy_after_pop accounts for a same-cycle transfer.
- With sink_ready held high, throughput is 1 sample/cycle.
- Latency: first buf_rd_en is asserted the cycle after frame_ready is sampled in IDLE. First sink_valid follows 2 cycles after that read.
- sink_valid, sink_data, sink_sop, sink_eop and sink_index are driven from the FIFO head. They stay stable while sink_valid && !sink_ready.
- sink_index increments per transferred beat. It wraps NSamples-1 -> 0 and equals the buffer read order.

Frame_ready during busy:
- If pending is clear, set pending. One frame is queued.
- If pending is already set, drop the new frame: pulse overrun, and increment frames_dropped (saturating at 2^DROP_W-1).
- frame_ready in the same cycle as the DRAIN->next transition: that transition consumes the old pending flag, and the new pulse sets pending again. Not an overrun.
- frame_ready while in IDLE is never an overrun.

Test Plan:
- Single frame, NSamples=8, sink_ready=1: frame_ready pulse -> 8 beats on consecutive cycles, sink_index 0..7, sop on beat 0, eop on beat 7, data equals buffer contents, frame_done 1 cycle after eop, busy low next cycle.
- Backpressure: sink_ready toggles 1,0,0,1,... -> all 8 samples delivered in order, no duplicates, outputs held stable while stalled, buf_rd_en never leaves more than 2 entries outstanding.
- Back-to-back: second frame_ready pulse at beat 3 -> second frame's sop follows the first frame_done with no IDLE cycle; frames_dropped stays 0.
- Overrun: three frame_ready pulses during one frame -> second pulse is queued, third pulse gives overrun pulse and frames_dropped=1. With DROP_W=2 and 5 drops, the counter saturates at 3.
- Reset at beat 4 with sink_ready=0: outputs go to 0 the next cycle, no eop, no frame_done. A fresh frame_ready then restarts at index 0 with sop.
- Simultaneous frame_ready and eop transfer with pending set -> no overrun, pending remains set, and a third frame streams after the second.
